uart_rx_oversample: RTL
=======================

// Module: uart_rx_oversample
// PURPOSE
//  Oversampling UART receiver; first stage of the tapeout UART receive path.
//  Recovers 8N1 frames from the asynchronous rx pin using a 16x tick from the baud generator.
//  Emits one-cycle done/err strobes that feed the rx FIFO write port.
//  Adds synchronisation, false-start rejection, 3-sample majority vote and framing/break handling.
// PARAMETERS
//  DATA_BITS    8   payload bits per frame, LSB first
//  OVERSAMPLE   16  en ticks per bit period; even, >=8
//  SYNC_STAGES  2   flops in rx input synchroniser, >=2
//  PARITY_ODD   0   parity sense (1=odd); used only with UART_RX_PARITY_EN
// PORTS
//  clk    in   1          system clock
//  nReset in   1          reset, synchronous, active-low
//  en     in   1          oversample tick (OVERSAMPLE x baud), 1 clk wide; may be held 1
//  in     in   1          raw serial line, idle high
//  data   out  DATA_BITS  last received payload; valid when done=1, held until next done
//  done   out  1          1-clk strobe: frame finished (good or bad)
//  err    out  1          1-clk strobe with done: framing or parity error
//  perr   out  1          1-clk strobe with done: parity error (tied 0 without macro)
//  busy   out  1          1 while in any state other than IDLE
// BEHAVIOUR
//  - Reset (nReset=0 at clk edge): state=IDLE, tick cnt=0, bit cnt=0.
//    Outputs on reset: data=0, done=0, err=0, perr=0, busy=0.
//    Synchroniser flops are set to 1. A frame in flight is abandoned; no done is issued.
//  - rx passes through SYNC_STAGES flops; "s" below is the synchronised value.
//  - Tick counter tc has width $clog2(OVERSAMPLE). It advances only on en=1 and is cleared on each state entry.
//  - Majority vote: s is sampled at tc=M-1, M, M+1, where M=OVERSAMPLE/2.
//    The bit value (2-of-3) is decided at tc=M+1.
//  - FSM states: IDLE, START, DATA, [PARITY], STOP, BREAK.
//    IDLE:   on en && s==0, enter START; that tick counts as tc=0.
//    START:  at the decision tick, vote==1 means false start -> IDLE, no strobe.
//            vote==0: count to tc=OVERSAMPLE-1, then enter DATA.
//    DATA:   at the decision tick, shift vote into shift reg (LSB first).
//            After OVERSAMPLE ticks per bit and DATA_BITS bits -> PARITY if macro defined, else STOP.
//    STOP:   at the decision tick, the frame ends immediately (no wait for bit end).
//            vote==1: data<=shift reg, done=1, err=perr_int; go to IDLE.
//            vote==0: data<=shift reg, done=1, err=1; go to BREAK.
//    BREAK:  wait for en && s==1, then IDLE. No further strobes while the line is held low.
//  - done/err/perr are registered and high exactly one clk, in the cycle after the STOP decision tick.
//  - With en held 1 and OVERSAMPLE=16, counting the first en with s==0 as tick 0:
//    START decision at tick 9; data bit i decided at tick 25+16i; STOP decision at tick 153.
//    done appears at clk 154.
//  - The next start bit is accepted from the cycle after the STOP decision.
//    This gives half-bit tolerance for back-to-back frames.
//  - en=0 freezes the FSM and counters; the synchroniser still runs every clk.
//  - No flow control: data is overwritten on every done; the consumer must capture it on the strobe.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//    PARITY state follows DATA, one bit period long, sampled by the same majority vote.
//    perr_int = received parity bit XOR (^payload) XOR PARITY_ODD.
//    perr_int is reported on perr and ORed into err at done. STOP timing shifts by OVERSAMPLE ticks.
//  UART_RX_PARITY_EN undefined:
//    No PARITY state; 8N1 only. perr is tied to 0; err reports framing errors only.
// TESTING
//  1. en=1, send 0xA5 as 8N1 -> exactly one done at clk 154; data=0xA5, err=0, busy falls with done.
//  2. Hold rx low for 4 ticks, then high (glitch) -> return to IDLE at tick 9; no done, data unchanged.
//  3. Frame 0x3C with stop bit 0, line then held low for 40 bit times.
//     -> one done with err=1 and data=0x3C; BREAK held; no further done until the line rises.
//  4. Back-to-back 0x00, 0xFF, 0x55 with no idle gap -> three done strobes, correct data, err=0.
//  5. Assert nReset mid-DATA of a 0x81 frame -> all outputs 0 next clk, no done.
//     The following clean frame 0x81 is received.
//  6. (UART_RX_PARITY_EN, PARITY_ODD=0) send 0x07 with parity bit 0
//     -> done with err=1, perr=1; with parity bit 1 -> err=0.

Source files
------------

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: oversampling UART receiver (8N1 by default).
// Synchronises the raw line, rejects false starts, majority-votes three
// samples around each bit centre and flags framing errors and line breaks.
// Optional build macro: UART_RX_PARITY_EN adds one parity bit after the data.
module uart_rx_oversample #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int PARITY_ODD  = 0
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 en,
  input  logic                 in,
  output logic [DATA_BITS-1:0] data,
  output logic                 done,
  output logic                 err,
  output logic                 perr,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int M  = OVERSAMPLE / 2;

  // Tick positions of the three vote samples and the end of a bit period.
  localparam logic [TW-1:0] TC_S1   = TW'(M - 1);
  localparam logic [TW-1:0] TC_S2   = TW'(M);
  localparam logic [TW-1:0] TC_DEC  = TW'(M + 1);
  localparam logic [TW-1:0] TC_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    LINE_BREAK
  } state_t;

  state_t               state, stateNext;
  logic [TW-1:0]        tc, tcNext;
  logic [BW-1:0]        bitCnt, bitCntNext;
  logic [DATA_BITS-1:0] shiftReg, shiftNext, dataNext;
  logic [1:0]           voteQ, voteNext;
  logic [SYNC_STAGES-1:0] syncQ;
  logic                 doneNext, errNext, perrNext;
  logic                 s, vote, perrInt;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_SENSE = 1'(PARITY_ODD);
  logic parBit, parNext;
  // Parity error: received parity bit disagrees with the payload parity.
  assign perrInt = parBit ^ (^shiftReg) ^ PAR_SENSE;
`else
  logic unusedParity;
  assign unusedParity = 1'(PARITY_ODD);
  assign perrInt      = 1'b0;
`endif

  assign s    = syncQ[SYNC_STAGES-1];
  assign vote = (voteQ[0] & voteQ[1]) | (voteQ[0] & s) | (voteQ[1] & s);
  assign busy = (state != IDLE);

  // Input synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value, independent of statement order.
    if (!nReset) syncQ <= '1;
    else         syncQ <= {syncQ[SYNC_STAGES-2:0], in};
  end

  // Control state and output strobes.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state  <= IDLE;
      tc     <= '0;
      bitCnt <= '0;
      data   <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      perr   <= 1'b0;
    end else begin
      state  <= stateNext;
      tc     <= tcNext;
      bitCnt <= bitCntNext;
      data   <= dataNext;
      done   <= doneNext;
      err    <= errNext;
      perr   <= perrNext;
    end
  end

  // Datapath registers: always written before being read within a frame.
  always_ff @(posedge clk) begin
    // NOTE: these flops carry no reset; their contents are overwritten
    // before any use, so a reset would only add load on nReset.
    shiftReg <= shiftNext;
    voteQ    <= voteNext;
`ifdef UART_RX_PARITY_EN
    parBit   <= parNext;
`endif
  end

  // Next-state, counter and strobe logic; everything advances only on en.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    stateNext  = state;
    tcNext     = tc;
    bitCntNext = bitCnt;
    shiftNext  = shiftReg;
    voteNext   = voteQ;
    dataNext   = data;
    doneNext   = 1'b0;
    errNext    = 1'b0;
    perrNext   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parNext    = parBit;
`endif
    if (en) begin
      tcNext = tc + 1'b1;
      if (tc == TC_S1) voteNext[0] = s;
      if (tc == TC_S2) voteNext[1] = s;
      case (state)
        IDLE: begin
          tcNext = '0;
          if (!s) begin
            stateNext = START;
            tcNext    = TW'(1);
          end
        end
        START: begin
          if (tc == TC_DEC && vote) begin
            stateNext = IDLE;
            tcNext    = '0;
          end else if (tc == TC_LAST) begin
            stateNext  = DATA;
            tcNext     = '0;
            bitCntNext = '0;
          end
        end
        DATA: begin
          if (tc == TC_DEC) shiftNext = {vote, shiftReg[DATA_BITS-1:1]};
          if (tc == TC_LAST) begin
            tcNext = '0;
            if (bitCnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              stateNext = PARITY;
`else
              stateNext = STOP;
`endif
            end else begin
              bitCntNext = bitCnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tc == TC_DEC) parNext = vote;
          if (tc == TC_LAST) begin
            stateNext = STOP;
            tcNext    = '0;
          end
        end
`endif
        STOP: begin
          // The frame ends at the stop-bit decision so the next start bit
          // can be caught half a bit early.
          if (tc == TC_DEC) begin
            dataNext  = shiftReg;
            doneNext  = 1'b1;
            errNext   = !vote | perrInt;
            perrNext  = perrInt;
            stateNext = vote ? IDLE : LINE_BREAK;
            tcNext    = '0;
          end
        end
        LINE_BREAK: begin
          tcNext = '0;
          if (s) stateNext = IDLE;
        end
        default: begin
          stateNext = IDLE;
          tcNext    = '0;
        end
      endcase
    end
  end

endmodule
